// File: rtl/barrel_cmd_queue.sv
// ---------------------------------------------------------------------------
// barrel_cmd_queue
//
// Buffered command front end and registered result stage for a 16-bit barrel
// shifter. Commands {type, amount, data} are queued in a DEPTH-entry FIFO.
// The FIFO head feeds a combinational barrel shifter. Each result is captured
// in an output register that has its own handshake.
//
// Optional feature macro: BARREL_Q_FLAGS_EN
//   defined     -> out_z / out_n are registered alongside out_data
//   not defined -> out_z / out_n are tied to 0 and no flag logic exists
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   in_valid   in   producer offers a command
//   in_ready   out  queue can accept (count != DEPTH, from registered count)
//   in_type    in   00 lsl, 01 lsr, 10 asr, 11 ror
//   in_shift   in   shift amount 0..15
//   in_data    in   16-bit operand
//   out_valid  out  out_data holds an unconsumed result
//   out_ready  in   consumer accepts the result
//   out_data   out  registered shift result
//   out_z      out  result == 0 (flags build only)
//   out_n      out  result bit 15 (flags build only)
//   count      out  FIFO occupancy 0..DEPTH (output register not included)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A valid source holds its payload stable until
// that edge. Ready never depends combinationally on valid.
// ---------------------------------------------------------------------------

module barrel (
  input  logic [1:0]  typ,
  input  logic [3:0]  amt,
  input  logic [15:0] data,
  output logic [15:0] result
);
  always_comb begin
    result = data;
    case (typ)
      2'b00:   result = data << amt;
      2'b01:   result = data >> amt;
      2'b10:   result = 16'($signed(data) >>> amt);
      // Shifting a 16-bit value left by 16 yields 0, so amt = 0 returns data.
      default: result = (data >> amt) | (data << (5'd16 - {1'b0, amt}));
    endcase
  end
endmodule

module barrel_cmd_queue #(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_type,
  input  logic [3:0]               in_shift,
  input  logic [15:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_z,
  output logic                     out_n,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately not reset; occupancy is tracked by count alone.
  logic [21:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           load;
  logic [21:0]    head;
  logic [15:0]    shift_res;

  // No pass-through at full: in_ready comes only from the registered count.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The output register can take a new result when empty or being drained.
  assign load     = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  barrel u_barrel (
    .typ    (head[21:20]),
    .amt    (head[19:16]),
    .data   (head[15:0]),
    .result (shift_res)
  );

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {in_type, in_shift, in_data};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= shift_res;
    end else if (out_ready) begin
      // Consumed with nothing behind it: data is held, only valid drops.
      out_valid <= 1'b0;
    end
  end

`ifdef BARREL_Q_FLAGS_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_z <= 1'b0;
      out_n <= 1'b0;
    end else if (load) begin
      out_z <= (shift_res == 16'h0000);
      out_n <= shift_res[15];
    end
  end
`else
  assign out_z = 1'b0;
  assign out_n = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_cmd_queue.sv
module tb_barrel_cmd_queue;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_type = 2'b00;
  logic [3:0]  in_shift = 4'h0;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_z;
  logic        out_n;
  logic [2:0]  count;

  logic        man_rdy = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic        rand_mode = 1'b0;
  assign out_ready = rand_mode ? rnd_rdy : man_rdy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 2) != 0);
  end

  barrel_cmd_queue #(.DEPTH(4)) dut (
    .Clock     (clk),
    .Resetn    (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_shift  (in_shift),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_z     (out_z),
    .out_n     (out_n),
    .count     (count)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {z, n, data}
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  s;
    logic [15:0] d;
    logic [15:0] e;
    logic        n;
  } vec_t;
  vec_t vec[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shifter: built bit by bit from the shift definitions.
  function automatic logic [15:0] model(input logic [1:0] t, input logic [3:0] s,
                                        input logic [15:0] d);
    logic [15:0] r;
    int src;
    for (int i = 0; i < 16; i++) begin
      case (t)
        2'b00: begin src = i - int'(s); r[i] = (src >= 0) ? d[src] : 1'b0; end
        2'b01: begin src = i + int'(s); r[i] = (src < 16) ? d[src] : 1'b0; end
        2'b10: begin src = i + int'(s); r[i] = (src < 16) ? d[src] : d[15]; end
        default: begin src = (i + int'(s)) % 16; r[i] = d[src]; end
      endcase
    end
    return r;
  endfunction

  function automatic logic [17:0] mk_exp(input logic [15:0] e, input logic n);
`ifdef BARREL_Q_FLAGS_EN
    return {(e == 16'h0000), n, e};
`else
    return {2'b00, e};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_cmd(input logic [1:0] t, input logic [3:0] s,
                          input logic [15:0] d, input logic [15:0] e, input logic n);
    int waited = 0;
    in_type = t; in_shift = s; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("push_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(mk_exp(e, n));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_vec(input int i);
    push_cmd(vec[i].t, vec[i].s, vec[i].d, vec[i].e, vec[i].n);
  endtask

  task automatic drain();
    int w = 0;
    man_rdy = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && w < 100) begin
      step(1);
      w++;
    end
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_count", {29'd0, count}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  rt;
    logic [3:0]  rs;
    logic [15:0] rd;
    logic [15:0] re;

    vec[0]  = '{2'b00, 4'd1,  16'hF0F0, 16'hE1E0, 1'b1};
    vec[1]  = '{2'b01, 4'd1,  16'hF0F0, 16'h7878, 1'b0};
    vec[2]  = '{2'b00, 4'd4,  16'hF0F0, 16'h0F00, 1'b0};
    vec[3]  = '{2'b01, 4'd4,  16'hF0F0, 16'h0F0F, 1'b0};
    vec[4]  = '{2'b10, 4'd4,  16'hF0F0, 16'hFF0F, 1'b1};
    vec[5]  = '{2'b11, 4'd0,  16'hF0F0, 16'hF0F0, 1'b1};
    vec[6]  = '{2'b11, 4'd4,  16'hF0F0, 16'h0F0F, 1'b0};
    vec[7]  = '{2'b11, 4'd8,  16'hF0F0, 16'hF0F0, 1'b1};
    vec[8]  = '{2'b10, 4'd1,  16'h8080, 16'hC040, 1'b1};
    vec[9]  = '{2'b10, 4'd4,  16'h8080, 16'hF808, 1'b1};
    vec[10] = '{2'b11, 4'd1,  16'h8080, 16'h4040, 1'b0};
    vec[11] = '{2'b11, 4'd15, 16'h8080, 16'h0101, 1'b0};

    // Output monitor: every consumed result is checked against the queue.
    fork
      forever begin
        logic [17:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {16'd0, out_data}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
            chk("out_z", {31'd0, out_z}, {31'd0, e[17]});
            chk("out_n", {31'd0, out_n}, {31'd0, e[16]});
          end
        end
      end
    join_none

    // Reset values
    step(2);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_z", {31'd0, out_z}, 0);
    chk("rst_out_n", {31'd0, out_n}, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // Single-command latency
    man_rdy = 1'b1;
    push_vec(0);
    chk("lat_valid_early", {31'd0, out_valid}, 0);
    chk("lat_count", {29'd0, count}, 1);
    step(1);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_data", {16'd0, out_data}, {16'd0, vec[0].e});
    step(1);
    chk("drain_valid_low", {31'd0, out_valid}, 0);
    chk("drain_data_held", {16'd0, out_data}, {16'd0, vec[0].e});

    // Table: back-to-back throughput, then the asr/ror patterns
    for (int i = 0; i < 4; i++) push_vec(i);
    chk("tput_count", {29'd0, count}, 1);
    chk("tput_data", {16'd0, out_data}, {16'd0, vec[2].e});
    drain();
    for (int i = 4; i < 12; i++) push_vec(i);
    drain();

    // Backpressure: 6 pushes with out_ready low
    man_rdy = 1'b0;
    fork
      begin
        for (int i = 4; i < 10; i++) push_vec(i);
      end
      begin
        step(12);
        chk("bp_count", {29'd0, count}, 4);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        chk("bp_valid", {31'd0, out_valid}, 1);
        chk("bp_data", {16'd0, out_data}, {16'd0, vec[4].e});
        step(3);
        chk("bp_data_stable", {16'd0, out_data}, {16'd0, vec[4].e});
        chk("bp_count_stable", {29'd0, count}, 4);
        man_rdy = 1'b1;
      end
    join
    drain();

    // Full queue with a one-cycle out_ready pulse
    man_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_vec(i);
    chk("full_count", {29'd0, count}, 4);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    in_type = vec[5].t; in_shift = vec[5].s; in_data = vec[5].d;
    in_valid = 1'b1;
    man_rdy = 1'b1;
    @(negedge clk);
    chk("pulse_in_ready", {31'd0, in_ready}, 0);
    step(1);
    man_rdy = 1'b0;
    chk("pulse_count", {29'd0, count}, 3);
    chk("pulse_in_ready_up", {31'd0, in_ready}, 1);
    @(negedge clk);
    if (in_ready) exp_q.push_back(mk_exp(vec[5].e, vec[5].n));
    step(1);
    in_valid = 1'b0;
    chk("pulse_refill", {29'd0, count}, 4);
    drain();

    // Asynchronous reset with 3 entries queued
    man_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(i);
    chk("pre_rst_count", {29'd0, count}, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 0);
    chk("arst_count", {29'd0, count}, 0);
    chk("arst_data", {16'd0, out_data}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    step(1);
    man_rdy = 1'b1;
    push_cmd(2'b00, 4'd15, 16'h0001, 16'h8000, 1'b1);
    push_cmd(2'b01, 4'd8, 16'h00FF, 16'h0000, 1'b0);
    drain();

    // Randomized traffic against the reference model
    rand_mode = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step($urandom_range(0, 2));
      rt = 2'($urandom_range(0, 3));
      rs = 4'($urandom_range(0, 15));
      rd = (k % 16 == 0) ? 16'h0000 : 16'($urandom);
      re = model(rt, rs, rd);
      push_cmd(rt, rs, rd, re, re[15]);
    end
    rand_mode = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
